// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the serial receive and transmit paths.
//   uart_rx_state_t            receiver FSM state encoding
//   CLKS_PER_BIT_115200_50MHZ  bit period in clocks for 115200 baud at 50 MHz
package uart_pkg;

  localparam int CLKS_PER_BIT_115200_50MHZ = 434;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// sync2: generic two-flop synchronizer for a single asynchronous input.
//   clk    destination clock
//   rst    asynchronous active-low reset; both flops load RST_VAL
//   d      asynchronous input
//   q      synchronized output (two clk edges of latency)
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_p0 <= RST_VAL;
      q       <= RST_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a single-byte holding register and a
// valid/ready output handshake.
//   clk        system clock
//   rst        asynchronous active-low reset
//   rx         raw serial line, asynchronous to clk, idles high
//   data       received byte, stable while valid is high
//   valid      data holds an unconsumed byte
//   ready      consumer accepts; transfer on valid & ready
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   overrun    one-cycle pulse when a byte completes while data is still held
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200_50MHZ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int                DATA_W    = 8;
  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic                rx_p0;
  logic                rx_p1;
  uart_rx_state_t      state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          bit_idx;
  logic [DATA_W-1:0]   shreg;
  logic                cnt_done;
  logic                xfer;

  assign cnt_done = (cnt == '0);
  assign xfer     = valid & ready;

  // Stage p0: metastability filter on the raw line
  sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_p0)
  );

  // Stage p1: registered copy of the synchronized line drives every FSM
  // decision, so the start edge is seen three edges after the line falls
  // and all samples land at the centre of their bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p1     <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_p1     <= rx_p0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (xfer) begin
        valid <= 1'b0;
      end

      unique case (state)
        RX_IDLE: begin
          if (!rx_p1) begin
            cnt   <= HALF_LOAD;
            state <= RX_START;
          end
        end

        RX_START: begin
          if (!cnt_done) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!rx_p1) begin
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
            state   <= RX_DATA;
          end else begin
            // line went back high by mid-bit: a glitch, not a start bit
            state <= RX_IDLE;
          end
        end

        RX_DATA: begin
          if (!cnt_done) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shreg[bit_idx] <= rx_p1;
            cnt            <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        RX_STOP: begin
          if (!cnt_done) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rx_p1) begin
            // a byte consumed on this very cycle frees the holding register
            if (!valid || ready) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            state <= RX_IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= RX_BREAK;
          end
        end

        RX_BREAK: begin
          // hold off until the line returns high so a stuck-low line
          // cannot be decoded as an endless stream of zero bytes
          if (rx_p1) begin
            state <= RX_IDLE;
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 8;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int t0       = 0;
  int rise_cyc = -1;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int rise_cnt = 0;

  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // posedge counter; cyc == k right after the k-th rising edge
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: flag pulse counting, valid edge timing, hold-stability and
  // scoreboard comparison of every transferred byte
  initial begin : monitor
    logic       prev_valid;
    logic       prev_xfer;
    logic [7:0] prev_data;
    prev_valid = 1'b0;
    prev_xfer  = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (valid === 1'b1 && !prev_valid) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
      if (prev_valid && !prev_xfer && valid === 1'b1 && rst)
        check("data_hold", 32'(data), 32'(prev_data));
      if (valid === 1'b1 && ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", data);
        end else begin
          check("rx_byte", 32'(data), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = (valid === 1'b1);
      prev_xfer  = (valid === 1'b1) && (ready === 1'b1);
      prev_data  = data;
    end
  end

  // all stimulus runs aligned to 1 ns after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // the first edge after the start bit is driven is edge 0 of the frame
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    t0   = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      tick(CPB);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r0;
    int f0;
    int o0;

    // reset state
    tick(3);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_state", 32'(dut.state), 32'(RX_IDLE));
    rst = 1'b1;
    tick(5);

    // single byte, ready tied high
    ready = 1'b1;
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(10);
    // first edge at which a consumer can take the byte: 4 + 4 + 72
    check("single_latency", 32'(rise_cyc - t0 + 1), 32'd80);
    check("single_valid_once", 32'(rise_cnt - r0), 32'd1);
    check("single_valid_low", 32'(valid), 32'h0);
    check("single_no_fe", 32'(fe_cnt - f0), 32'd0);
    check("single_no_ov", 32'(ov_cnt - o0), 32'd0);

    // glitch reject
    r0 = rise_cnt;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(20);
    check("glitch_idle", 32'(dut.state), 32'(RX_IDLE));
    check("glitch_no_valid", 32'(rise_cnt - r0), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    tick(10);
    check("glitch_next_frame", 32'(rise_cnt - r0), 32'd1);

    // framing error, then line held low as a break
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    tick(40);
    rx = 1'b1;
    tick(10);
    check("frame_err_once", 32'(fe_cnt - f0), 32'd1);
    check("frame_err_no_valid", 32'(rise_cnt - r0), 32'd0);
    check("frame_err_state", 32'(dut.state), 32'(RX_IDLE));
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    tick(10);
    check("frame_err_next_frame", 32'(rise_cnt - r0), 32'd1);
    check("frame_err_no_more", 32'(fe_cnt - f0), 32'd1);

    // overrun: two back-to-back frames with no consumer
    ready = 1'b0;
    o0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(5);
    check("overrun_once", 32'(ov_cnt - o0), 32'd1);
    check("overrun_valid_held", 32'(valid), 32'h1);
    check("overrun_data_kept", 32'(data), 32'h11);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("overrun_drained", 32'(valid), 32'h0);

    // consume on exactly the stop-sample edge of the next byte
    o0 = ov_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    tick(3);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (79) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    tick(2);
    check("simul_no_ov", 32'(ov_cnt - o0), 32'd0);
    check("simul_valid", 32'(valid), 32'h1);
    check("simul_data", 32'(data), 32'h22);
    ready = 1'b1;
    tick(1);
    check("simul_drained", 32'(valid), 32'h0);

    // asynchronous reset during data bit 4 of a frame
    fork
      send_frame(8'h5A, 1'b1);
      begin
        repeat (43) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_data", 32'(data), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        check("midrst_overrun", 32'(overrun), 32'h0);
        check("midrst_state", 32'(dut.state), 32'(RX_IDLE));
      end
    join
    tick(3);
    rst = 1'b1;
    tick(5);
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    tick(10);
    check("post_rst_valid", 32'(rise_cnt - r0), 32'd1);
    check("post_rst_no_fe", 32'(fe_cnt - f0), 32'd0);
    check("post_rst_no_ov", 32'(ov_cnt - o0), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the board's USB-serial input pin (`usb_rx`). It decodes 8N1 frames (one start bit, 8 data bits LSB-first, one stop bit) into bytes and presents them on a valid/ready handshake. Consumers are the CPU core or a host-command block. It is the receive-side counterpart to the existing serial output path.

## Interface

Parameters:

- `CLKS_PER_BIT`, default 434 (50 MHz / 115200): clock cycles per bit period. Legal range is ≥ 4.

Ports:

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  raw serial line, asynchronous to `clk`; idles high.
- `data`  out  8  received byte; stable while `valid` = 1.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts; a transfer occurs on a cycle with `valid` & `ready`.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a byte completes while the holding register is full.

## Operation

- `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- **IDLE**: when the synchronized rx = 0, load the bit counter with `CLKS_PER_BIT/2 - 1` (integer division) and go to START.
- **START**: when the counter reaches 0, resample.
  - rx = 0: load `CLKS_PER_BIT - 1`, clear the bit index, go to DATA.
  - rx = 1: treat as a glitch and return to IDLE. No flag is raised.
- **DATA**: at each counter expiry, shift rx into the shift register at position bit_idx (LSB first) and reload the counter. After bit 7, go to STOP.
- **STOP**: at counter expiry, sample rx.
  - rx = 1: the frame is good. If `valid` = 0, or `valid` & `ready` on this same cycle, load `data` and set `valid`. Otherwise drop the new byte, pulse `overrun`, and leave `data` unchanged. Return to IDLE.
  - rx = 0: pulse `frame_err`, discard the byte, go to BREAK.
- **BREAK**: wait for the synchronized rx = 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Handshake: `valid` clears on the cycle after a transfer unless a new byte loads on that same cycle. `data` never changes while `valid` = 1 and no transfer occurs.
- Counter width is `$clog2(CLKS_PER_BIT)`. The bit index is 3 bits and never wraps past 7.

## Timing

- Reset values: `data` = 0, `valid` = 0, `frame_err` = 0, `overrun` = 0, FSM = IDLE, synchronizer = 1, counters = 0.
- Reset is asynchronous. Asserting it mid-frame aborts the frame with no flags. After release the block waits in IDLE for a fresh falling edge. A line that is low at release is treated as a start bit.
- Define cycle 0 as the first `clk` edge that samples `rx` low. Then:
  - START is entered at cycle 3.
  - The start bit is confirmed at cycle 3 + `CLKS_PER_BIT/2`.
  - Data bit k is sampled at cycle 3 + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
  - `valid` / `frame_err` / `overrun` are visible at cycle 4 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- Back-to-back frames need no idle gap. IDLE re-arms on the cycle after the STOP sample, half a bit before the nominal stop-bit end.
- `ready` is permitted to be tied high. No combinational path runs from `ready` to any output.

## Structure

- A shared package `uart_pkg` holds the FSM state enum (`uart_rx_state_t`) and the `CLKS_PER_BIT_115200_50MHZ` = 434 constant, for reuse by the transmitter.
- One sub-module, `sync2`: the generic 2-flop synchronizer with a reset value parameter. It is reused later for `io_button` / `io_dip`.
- Top-level integration: `main` instantiates `uart_rx` on `usb_rx` with the same `clk` and `rst`.

## Test plan

Use `CLKS_PER_BIT` = 8 unless stated otherwise.

- **Single byte**: drive frame 0xA5 with `ready` = 1 → `valid` pulses exactly once at cycle 4+4+72 = 80 with `data` = 0xA5, and no flags.
- **Glitch reject**: pulse `rx` low for 2 cycles → no `valid`, FSM back in IDLE. A following frame 0x3C is received correctly.
- **Framing error**: frame 0x55 with stop bit low, then `rx` held low for 40 cycles, then high → one `frame_err` pulse, no `valid`. The next frame 0x0F is received.
- **Overrun**: `ready` = 0, send 0x11 then 0x22 back-to-back → `data` = 0x11 with `valid` held and one `overrun` pulse. Raising `ready` transfers 0x11, then `valid` = 0.
- **Simultaneous consume**: hold 0x11 unconsumed and assert `ready` exactly on the STOP-sample cycle of 0x22 → no `overrun`, `valid` stays 1, `data` = 0x22.
- **Reset mid-frame**: assert `rst` = 0 during data bit 4 → all outputs are 0 immediately. After release, a clean frame 0xFF is received with no flags.
